// File: rtl/deserializer_impl.sv
// Serial-to-parallel deserializer: rebuilds MSB-first frames into left-aligned words.
// Optional DESERIALIZER_FRAME_ERR_EN adds frame_err_o, which pulses on a discarded short frame.
module deserializer_impl #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4,
  parameter int MIN_FRAME_LEN  = 3
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
`ifdef DESERIALIZER_FRAME_ERR_EN
  ,
  output logic                      frame_err_o
`endif
);

  localparam int CW = DATA_MOD_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t                    r_state;
  logic [DATA_BUS_WIDTH-1:0] r_buf;
  logic [CW-1:0]             r_cnt;
  logic [DATA_BUS_WIDTH-1:0] r_data;
  logic [DATA_MOD_WIDTH-1:0] r_mod;
  logic                      r_val;
  logic                      r_busy;
`ifdef DESERIALIZER_FRAME_ERR_EN
  logic                      r_err;
`endif

  logic [DATA_BUS_WIDTH-1:0] w_first_buf;
  logic [DATA_MOD_WIDTH-1:0] w_idx;
  logic                      w_last_bit;
  logic                      w_accept;

  // A new frame starts with every LSB cleared so stale bits never leak through.
  assign w_first_buf = {ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}};
  assign w_idx       = DATA_MOD_WIDTH'(DATA_BUS_WIDTH-1) - r_cnt[DATA_MOD_WIDTH-1:0];
  assign w_last_bit  = (r_cnt == CW'(DATA_BUS_WIDTH-1));
  assign w_accept    = (r_cnt >= CW'(MIN_FRAME_LEN));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DESERIALIZER_FRAME_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_val <= 1'b0;
`ifdef DESERIALIZER_FRAME_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (ser_data_val_i) begin
            r_buf   <= w_first_buf;
            r_cnt   <= CW'(1);
            r_state <= S_COLLECT;
            r_busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (ser_data_val_i) begin
            r_buf[w_idx] <= ser_data_i;
            r_cnt        <= r_cnt + CW'(1);
            if (w_last_bit) begin
              r_state <= S_EMIT;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= S_EMIT;
            r_busy  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            r_data <= r_buf;
            r_mod  <= r_cnt[DATA_MOD_WIDTH-1:0];
            r_val  <= 1'b1;
          end
`ifdef DESERIALIZER_FRAME_ERR_EN
          else begin
            r_err <= 1'b1;
          end
`endif
          // A valid bit in the emit cycle opens the next frame without losing it.
          if (ser_data_val_i) begin
            r_buf   <= w_first_buf;
            r_cnt   <= CW'(1);
            r_state <= S_COLLECT;
            r_busy  <= 1'b1;
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign busy_o           = r_busy;
`ifdef DESERIALIZER_FRAME_ERR_EN
  assign frame_err_o      = r_err;
`endif

endmodule
